// File: rtl/fpu_types.sv
// Shared FP datapath types: the intermediate writeback payload passed from the
// FP producers (misc/add/mul/div-sqrt) to the normalization/rounding stage.
package fpu_types;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MANT_W  = 23;
   localparam int unsigned ID_W    = 8;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned RM_W    = 3;
   localparam int unsigned FLAGS_W = 5;
   localparam int unsigned CLZ_W   = 6;
   localparam int unsigned SHIFT_W = 6;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  expo;
      logic [MANT_W-1:0] mant;
   } fp_t;

   typedef struct packed {
      logic guard;
      logic round;
      logic sticky;
   } grs_t;

   typedef logic [SHIFT_W-1:0] fp_shift_amt_t;

   typedef struct packed {
      logic [ID_W-1:0]    id;
      logic [RD_W-1:0]    rd;
      logic [RM_W-1:0]    rm;
      logic [FLAGS_W-1:0] fflags;
      logic               hidden;
      grs_t               grs;
      logic [CLZ_W-1:0]   clz;
      logic               carry;
      logic               safe;
      logic               expo_overflow;
      logic               right_shift;
      fp_shift_amt_t      right_shift_amt;
      logic               subnormal;
      logic               ignore_max_expo;
      logic               d2s;
   } fp_intermediate_wb_t;

   // Index increment modulo n, used to advance round-robin pointers.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

// File: rtl/fp_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// scanning upward and wrapping modulo WIDTH.
module fp_rr_picker #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             any_o
);

   logic [IDX_W:0] cand_s;

   // Walk the offsets from ptr_i; the extra bit keeps ptr+offset from overflowing before the wrap.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      cand_s   = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         cand_s = {1'b0, ptr_i} + (IDX_W+1)'(k);
         cand_s = (cand_s >= (IDX_W+1)'(WIDTH)) ? (cand_s - (IDX_W+1)'(WIDTH)) : cand_s;
         if (!any_o && req_i[cand_s[IDX_W-1:0]]) begin
            any_o    = 1'b1;
            winner_o = cand_s[IDX_W-1:0];
         end else begin
            any_o    = any_o;
            winner_o = winner_o;
         end
      end
   end

endmodule

// File: rtl/fp_intermediate_wb_arbiter.sv
// Round-robin arbiter collecting intermediate FP results into a one-entry
// pipeline register that feeds the shared normalization/rounding stage.
module fp_intermediate_wb_arbiter
   import fpu_types::*;
#(
   parameter  int unsigned NUM_UNITS = 4,
   localparam int unsigned SRC_W     = $clog2(NUM_UNITS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_UNITS-1:0]                unit_done,
   input  fp_intermediate_wb_t [NUM_UNITS-1:0] unit_data,
   output logic [NUM_UNITS-1:0]                unit_ack,
   output logic                                out_valid,
   output fp_intermediate_wb_t                 out_data,
   output logic [SRC_W-1:0]                    out_src,
   input  logic                                out_ready
);

   logic                valid_q, valid_d;
   fp_intermediate_wb_t data_q,  data_d;
   logic [SRC_W-1:0]    src_q,   src_d;
   logic [SRC_W-1:0]    ptr_q,   ptr_d;

   logic                accept_s;
   logic                grant_s;
   logic                any_s;
   logic [SRC_W-1:0]    winner_s;

   fp_rr_picker #(
      .WIDTH (NUM_UNITS)
   ) u_picker (
      .req_i    (unit_done),
      .ptr_i    (ptr_q),
      .winner_o (winner_s),
      .any_o    (any_s)
   );

   // A grant needs a slot that is empty or draining this cycle; acks stay low while reset is held.
   always_comb begin
      accept_s = ~valid_q | out_ready;
      grant_s  = any_s & accept_s & rst;
   end

   // One-hot ack back to the winning producer; it doubles as that unit's issue ready.
   always_comb begin
      unit_ack = '0;
      if (grant_s) begin
         unit_ack[winner_s] = 1'b1;
      end else begin
         unit_ack = '0;
      end
   end

   // Load on grant (also covers retire-and-refill), drain when consumed, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      if (grant_s) begin
         valid_d = 1'b1;
         data_d  = unit_data[winner_s];
         src_d   = winner_s;
         ptr_d   = SRC_W'(wrap_inc(32'(winner_s), NUM_UNITS));
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Pipeline register and priority pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_fp_intermediate_wb_arbiter.sv
// Bench for fp_intermediate_wb_arbiter: directed vector table, async reset
// sequence, randomized traffic against a queue-style reference, and a 2-unit build.
module tb_fp_intermediate_wb_arbiter;
   import fpu_types::*;

   localparam int N = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [3:0]                unit_done;
   fp_intermediate_wb_t [3:0] unit_data;
   logic [3:0]                unit_ack;
   logic                      out_valid;
   fp_intermediate_wb_t       out_data;
   logic [1:0]                out_src;
   logic                      out_ready;

   logic [1:0]                done2;
   fp_intermediate_wb_t [1:0] data2;
   logic [1:0]                ack2;
   logic                      valid2;
   fp_intermediate_wb_t       odata2;
   logic                      src2;
   logic                      ready2;

   int total = 0;
   int bad   = 0;

   // reference state
   int                  m_ptr;
   logic                m_valid;
   fp_intermediate_wb_t m_data;
   int                  m_src;

   typedef struct {
      logic [3:0] done;
      logic       ready;
      logic [3:0] ack;
      logic       valid;
      logic [1:0] src;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   fp_intermediate_wb_arbiter #(.NUM_UNITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .unit_done (unit_done),
      .unit_data (unit_data),
      .unit_ack  (unit_ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   fp_intermediate_wb_arbiter #(.NUM_UNITS(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .unit_done (done2),
      .unit_data (data2),
      .unit_ack  (ack2),
      .out_valid (valid2),
      .out_data  (odata2),
      .out_src   (src2),
      .out_ready (ready2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fp_intermediate_wb_t rand_payload();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return fp_intermediate_wb_t'(r[$bits(fp_intermediate_wb_t)-1:0]);
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
   endtask

   // One cycle: drive inputs, check ack, clock, check the registered result.
   task automatic step(input logic [3:0] d, input logic r, output logic [3:0] got_ack);
      int         win;
      logic [3:0] e_ack;
      unit_done = d;
      out_ready = r;
      #1;
      win = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (win < 0 && d[idx]) win = idx;
      end
      e_ack = 4'b0000;
      if (win >= 0 && (!m_valid || r)) e_ack[win] = 1'b1;
      chk("ack", 64'(unit_ack), 64'(e_ack));
      got_ack = unit_ack;
      @(posedge clk);
      if (e_ack != 4'b0000) begin
         m_data  = unit_data[win];
         m_src   = win;
         m_valid = 1'b1;
         m_ptr   = (win + 1) % N;
      end else if (r) begin
         m_valid = 1'b0;
      end
      #1;
      chk("valid", 64'(out_valid), 64'(m_valid));
      chk("src", 64'(out_src), 64'(m_src));
      chk("data", 64'(out_data), 64'(m_data));
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      unit_done = 4'b0000;
      out_ready = 1'b0;
      done2     = 2'b00;
      ready2    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic add_vec(input logic [3:0] d, input logic r, input logic [3:0] a,
                          input logic v, input logic [1:0] s);
      vec_t t;
      t.done = d; t.ready = r; t.ack = a; t.valid = v; t.src = s;
      vecs.push_back(t);
   endtask

   task automatic step2(input logic [1:0] d, input logic [1:0] e_ack, input logic e_src);
      done2 = d;
      #1;
      chk("n2_ack", 64'(ack2), 64'(e_ack));
      @(posedge clk);
      #1;
      chk("n2_valid", 64'(valid2), 64'd1);
      chk("n2_src", 64'(src2), 64'(e_src));
      chk("n2_id", 64'(odata2.id), e_src ? 64'd9 : 64'd2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] got;
      logic [3:0] pend;

      for (int i = 0; i < N; i++) begin
         unit_data[i]    = '0;
         unit_data[i].id = 8'(2 * i + 1);
      end
      data2       = '0;
      data2[0].id = 8'd2;
      data2[1].id = 8'd9;

      rst       = 1'b1;
      unit_done = 4'b0000;
      out_ready = 1'b0;
      done2     = 2'b00;
      ready2    = 1'b1;
      #2;
      do_reset();
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_src", 64'(out_src), 64'd0);
      chk("reset_data", 64'(out_data), 64'd0);

      // hand-derived sequence: single requester, wrap, fairness, backpressure, drain
      add_vec(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
      add_vec(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
      add_vec(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3);
      for (int i = 0; i < 8; i++)
         add_vec(4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4));
      for (int i = 0; i < 3; i++)
         add_vec(4'b1010, 1'b0, 4'b0000, 1'b1, 2'd3);
      add_vec(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
      add_vec(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3);
      add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
      add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3);
      add_vec(4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
      add_vec(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);

      foreach (vecs[i]) begin
         step(vecs[i].done, vecs[i].ready, got);
         chk($sformatf("tbl%0d_ack", i), 64'(got), 64'(vecs[i].ack));
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vecs[i].valid));
         chk($sformatf("tbl%0d_src", i), 64'(out_src), 64'(vecs[i].src));
         if (i == 0) chk("tbl0_id", 64'(out_data.id), 64'd5);
      end

      // async reset while holding a result with unit 2 requesting
      unit_done = 4'b0100;
      out_ready = 1'b0;
      #1;
      chk("pre_rst_ack", 64'(unit_ack), 64'd0);
      #1;
      rst = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_ack", 64'(unit_ack), 64'd0);
      chk("async_src", 64'(out_src), 64'd0);
      chk("async_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1;
      chk("in_rst_valid", 64'(out_valid), 64'd0);
      chk("in_rst_ack", 64'(unit_ack), 64'd0);
      rst = 1'b1;
      model_reset();
      step(4'b0100, 1'b1, got);
      chk("rel_ack", 64'(got), 64'b0100);
      chk("rel_id", 64'(out_data.id), 64'd5);
      step(4'b1001, 1'b1, got);
      chk("rel_next_ack", 64'(got), 64'b1000);

      // randomized traffic; producers hold done and payload until acked
      do_reset();
      pend = 4'b0000;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               unit_data[i] = rand_payload();
               pend[i]      = (c % 300 < 100) ? 1'b1 : 1'($urandom_range(1, 0));
            end
         end
         step(pend, ($urandom_range(3, 0) != 0) || (c % 300 < 100), got);
         pend = pend & ~got;
      end

      // two-unit build: strict alternation
      do_reset();
      unit_done = 4'b0000;
      out_ready = 1'b1;
      step2(2'b11, 2'b01, 1'b0);
      step2(2'b11, 2'b10, 1'b1);
      step2(2'b11, 2'b01, 1'b0);
      step2(2'b01, 2'b01, 1'b0);
      step2(2'b10, 2'b10, 1'b1);
      step2(2'b01, 2'b01, 1'b0);
      step2(2'b10, 2'b10, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
